// File: rtl/log_event_arbiter.sv
// Round-robin event logger front end: severity filter, timestamping and a
// record FIFO draining through a valid/ready stream.
module log_event_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int CODE_WIDTH = 8,
    parameter int TS_WIDTH   = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [2:0]                        verbosity,
    input  logic [NUM_SRC-1:0]                req_valid,
    input  logic [3*NUM_SRC-1:0]              req_level,
    input  logic [CODE_WIDTH*NUM_SRC-1:0]     req_code,
    output logic [NUM_SRC-1:0]                req_ready,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [$clog2(NUM_SRC)-1:0]        out_src,
    output logic [2:0]                        out_level,
    output logic [CODE_WIDTH-1:0]             out_code,
    output logic [TS_WIDTH-1:0]               out_ts,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
    output logic [15:0]                       filtered_count
);
    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [SRC_W-1:0]      src;
        logic [2:0]            level;
        logic [CODE_WIDTH-1:0] code;
        logic [TS_WIDTH-1:0]   ts;
    } rec_t;

    logic [NUM_SRC-1:0][2:0]            level_a;
    logic [NUM_SRC-1:0][CODE_WIDTH-1:0] code_a;
    assign level_a = req_level;
    assign code_a  = req_code;

    logic [TS_WIDTH-1:0] ts;
    logic [SRC_W-1:0]    last_grant;
    logic [SRC_W-1:0]    grant_idx;
    logic [SRC_W-1:0]    cand;
    logic                found;
    logic [PTR_W:0]      wr_ptr;
    logic [PTR_W:0]      rd_ptr;
    rec_t                mem [FIFO_DEPTH];
    rec_t                head;
    rec_t                new_rec;
    logic                full;
    logic                pass;
    logic                push;
    logic                pop;
    logic                filt;

    assign fifo_count = wr_ptr - rd_ptr;
    assign full       = (fifo_count == ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH));
    assign out_valid  = (fifo_count != '0);
    assign pop        = out_valid && out_ready;

    // Round-robin search starting just after the last winner; no grant while
    // full (even if a pop is happening) or while reset is held.
    always_comb begin
        req_ready = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        if (!reset && !full) begin
            for (int k = 1; k <= NUM_SRC; k++) begin
                cand = SRC_W'((int'(last_grant) + k) % NUM_SRC);
                if (!found && req_valid[cand]) begin
                    found     = 1'b1;
                    grant_idx = cand;
                end
            end
            if (found) req_ready[grant_idx] = 1'b1;
        end
    end

    assign pass = (verbosity >= 3'd1) && (verbosity <= 3'd5) &&
                  (level_a[grant_idx] <= 3'd5) && (level_a[grant_idx] >= verbosity);
    assign push = found && pass;
    assign filt = found && !pass;

    assign new_rec = '{src: grant_idx, level: level_a[grant_idx],
                       code: code_a[grant_idx], ts: ts};

    always_ff @(posedge clk) begin
        if (reset) begin
            ts             <= '0;
            last_grant     <= SRC_W'(NUM_SRC - 1);
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            filtered_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            ts <= ts + 1'b1;
            if (found) last_grant <= grant_idx;
            if (push) begin
                mem[wr_ptr[PTR_W-1:0]] <= new_rec;
                wr_ptr                 <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (filt && filtered_count != 16'hFFFF) filtered_count <= filtered_count + 16'd1;
        end
    end

    assign head      = mem[rd_ptr[PTR_W-1:0]];
    assign out_src   = head.src;
    assign out_level = head.level;
    assign out_code  = head.code;
    assign out_ts    = head.ts;
endmodule
